// File: rtl/ws2812_frame_sequencer_if.sv
// ws2812_frame_sequencer_if: driver handshake, host write port and swap status of the frame sequencer
interface ws2812_frame_sequencer_if #(parameter int ADDR_W = 6);
  logic              drv_data_request;
  logic [ADDR_W-1:0] drv_address;
  logic [7:0]        red_out;
  logic [7:0]        green_out;
  logic [7:0]        blue_out;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [23:0]       wr_data;
  logic [7:0]        brightness;
  logic              swap_req;
  logic              swap_pending;
  logic              swap_ack;
  logic              frame_start;
  logic              front_bank;
  modport master (
    output drv_data_request, drv_address, wr_en, wr_addr, wr_data, brightness, swap_req,
    input  red_out, green_out, blue_out, swap_pending, swap_ack, frame_start, front_bank
  );
  modport slave (
    input  drv_data_request, drv_address, wr_en, wr_addr, wr_data, brightness, swap_req,
    output red_out, green_out, blue_out, swap_pending, swap_ack, frame_start, front_bank
  );
endinterface

// File: rtl/ws2812_frame_sequencer.sv
// ws2812_frame_sequencer: double-buffered pixel store serving brightness-scaled RGB to the ws2812 driver
module ws2812_frame_sequencer #(
  parameter int NUM_LEDS = 64,
  parameter int ADDR_W   = $clog2(NUM_LEDS)
) (
  input logic clk,
  input logic reset,
  ws2812_frame_sequencer_if.slave bus
);
  typedef enum logic {IDLE, STREAM} state_t;
  localparam logic [ADDR_W:0] N = (ADDR_W+1)'(NUM_LEDS);
  logic [23:0] mem [2][2**ADDR_W];
  state_t state, state_n;
  logic [ADDR_W:0] rd_idx, rd_idx_n;
  logic front, front_n, pend, pend_n, ack, fs, boundary, swap;
  logic [23:0] pix, rgb, rgb_n;
  function automatic logic [7:0] scale(input logic [7:0] c, input logic [7:0] b);
    logic [15:0] p;
    p = {8'd0, c} * ({8'd0, b} + 16'd1);
    return p[15:8];
  endfunction
  always_ff @(posedge clk)
    if (bus.wr_en && {1'b0, bus.wr_addr} < N) mem[~front][bus.wr_addr] <= bus.wr_data;
  // asynchronous read lets the boundary serve pixel 0 of the new front bank with one-cycle latency
  always_comb begin
    boundary = bus.drv_data_request && bus.drv_address == '0;
    swap = boundary && pend;
    front_n = front ^ swap;
    pend_n = !swap && (pend || bus.swap_req);
    state_n = boundary ? STREAM : state;
    pix = boundary ? mem[front_n][0] :
          (state == STREAM && rd_idx < N) ? mem[front][rd_idx[ADDR_W-1:0]] : 24'd0;
    rgb_n = bus.drv_data_request ? {scale(pix[23:16], bus.brightness),
                                    scale(pix[15:8], bus.brightness),
                                    scale(pix[7:0], bus.brightness)} : rgb;
    rd_idx_n = boundary ? (ADDR_W+1)'(1) :
               (bus.drv_data_request && state == STREAM && rd_idx < N) ? rd_idx + 1'b1 : rd_idx;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state  <= IDLE;
      rd_idx <= '0;
      front  <= 1'b0;
      pend   <= 1'b0;
      ack    <= 1'b0;
      fs     <= 1'b0;
      rgb    <= '0;
    end else begin
      state  <= state_n;
      rd_idx <= rd_idx_n;
      front  <= front_n;
      pend   <= pend_n;
      ack    <= swap;
      fs     <= boundary;
      rgb    <= rgb_n;
    end
  assign {bus.red_out, bus.green_out, bus.blue_out} = rgb;
  assign bus.swap_pending = pend;
  assign bus.swap_ack     = ack;
  assign bus.frame_start  = fs;
  assign bus.front_bank   = front;
endmodule
